lsu_dmem: RTL and testbench

Parametrised load/store data memory that replaces the single-cycle, word-only data memory behind the RISC-V core. It adds sub-word access (lb, lbu, lh, lhu, sb, sh, lw, sw) selected directly by the instruction's funct3, along with sign/zero extension and byte-lane writes. It also provides a configurable access latency behind a valid/ready request and valid response handshake, plus error reporting for misaligned, out-of-range and illegal accesses. It sits between the core's ALU result and store-data outputs and the writeback result mux, and it lets the core move to a multicycle or stalling design.

---
 rtl/lsu_dmem.sv | 181 ++++++++++++++++++
 tb/tb_lsu_dmem.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem.sv
// Load/store data memory with RISC-V sub-word access, configurable response latency
// and fault reporting for illegal, misaligned and out-of-range requests.
module lsu_dmem #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
  localparam logic [2:0]  LatInit = 3'(LATENCY);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic            idle;
  logic            cur_we;
  logic [2:0]      cur_funct3;
  logic [31:0]     cur_addr;
  logic [31:0]     cur_wdata;
  logic [IdxW-1:0] idx;
  logic [1:0]      lane;
  logic            illegal, misaligned, out_of_range, fault;
  logic [31:0]     word;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [31:0]     load_val;
  logic [3:0]      be;
  logic [31:0]     wlanes;
  logic            enter_resp;
  logic            mem_we;

  assign idle = (state_q == StIdle);

  // With LATENCY = 0 the access completes on the accept edge, so decode the live request.
  assign cur_we     = idle ? req_we     : we_q;
  assign cur_funct3 = idle ? req_funct3 : funct3_q;
  assign cur_addr   = idle ? req_addr   : addr_q;
  assign cur_wdata  = idle ? req_wdata  : wdata_q;

  assign idx  = cur_addr[IdxW+1:2];
  assign lane = cur_addr[1:0];
  assign word = mem[idx];

  always_comb begin
    illegal = 1'b1;
    if (cur_we) begin
      if (cur_funct3 inside {3'b000, 3'b001, 3'b010}) illegal = 1'b0;
    end else begin
      if (cur_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) illegal = 1'b0;
    end

    misaligned = 1'b0;
    case (cur_funct3[1:0])
      2'b01:   misaligned = cur_addr[0];
      2'b10:   misaligned = |cur_addr[1:0];
      default: misaligned = 1'b0;
    endcase

    out_of_range = |(cur_addr[31:2] >> IdxW);
    fault        = illegal | misaligned | out_of_range;
  end

  always_comb begin
    byte_v   = word[{lane, 3'b000} +: 8];
    half_v   = word[{cur_addr[1], 4'b0000} +: 16];
    load_val = '0;
    case (cur_funct3)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_val = {24'h0, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b101:  load_val = {16'h0, half_v};
      3'b010:  load_val = word;
      default: load_val = '0;
    endcase
  end

  always_comb begin
    be     = 4'b0000;
    wlanes = cur_wdata;
    case (cur_funct3[1:0])
      2'b00: begin
        be     = 4'b0001 << lane;
        wlanes = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be     = cur_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{cur_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          cnt_d    = LatInit;
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          state_d  = (LATENCY == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    enter_resp = (state_d == StResp) && (state_q != StResp);
    mem_we     = enter_resp & cur_we & ~fault;
    // Response fields live only for the RESP cycle and read as zero otherwise.
    rdata_d    = (enter_resp && !cur_we && !fault) ? load_val : 32'h0;
    err_d      = enter_resp & fault;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && be[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
    end
  end

  assign req_ready = idle;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_dmem.sv
// Bench for lsu_dmem: four instances (LATENCY 1, 0, 7, 3) driven by a vector table,
// a back-to-back throughput sequence and a mid-operation reset sequence.
module tb_lsu_dmem;

  logic        clk;
  logic        rst_n  [4];
  logic        rv     [4];
  logic        rdy    [4];
  logic        tb_we  [4];
  logic [2:0]  tb_f3  [4];
  logic [31:0] tb_addr[4];
  logic [31:0] tb_wd  [4];
  logic        vld    [4];
  logic [31:0] rd     [4];
  logic        err    [4];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    lsu_dmem #(
      .DEPTH_WORDS(256),
      .LATENCY    ((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 7 : 3)
    ) u_dut (
      .clk       (clk),
      .reset     (rst_n[g]),
      .req_valid (rv[g]),
      .req_ready (rdy[g]),
      .req_we    (tb_we[g]),
      .req_funct3(tb_f3[g]),
      .req_addr  (tb_addr[g]),
      .req_wdata (tb_wd[g]),
      .rsp_valid (vld[g]),
      .rsp_rdata (rd[g]),
      .rsp_err   (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      2:       return 7;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on instance d; returns response data, edges from accept to response, and
  // the number of sampled cycles with req_ready low up to and including the response.
  task automatic txn(input int d, input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] wdat, output logic [31:0] r, output logic e,
                     output int lat, output int nlow);
    @(negedge clk);
    tb_we[d] = w; tb_f3[d] = f; tb_addr[d] = a; tb_wd[d] = wdat; rv[d] = 1'b1;
    @(posedge clk); #1;
    rv[d] = 1'b0;
    tb_f3[d] = 3'b111; tb_addr[d] = 32'h0; tb_wd[d] = 32'hA5A5A5A5;
    lat = -1; nlow = 0; r = 32'h0; e = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!rdy[d]) nlow++;
      if (vld[d]) begin
        lat = i; r = rd[d]; e = err[d];
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check($sformatf("dut%0d_post_ready", d), 32'(rdy[d]), 32'h1);
    check($sformatf("dut%0d_post_valid", d), 32'(vld[d]), 32'h0);
    check($sformatf("dut%0d_post_rdata", d), rd[d], 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vt[24];

  initial begin
    logic [31:0] r;
    logic        e;
    int          lat, nlow;
    int          last_acc[4];
    int          nacc[4];
    logic        prev_v[4];
    int          nrsp;

    vt[0]  = '{1'b1, 3'b010, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vt[1]  = '{1'b1, 3'b010, 32'h0000_0064, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vt[2]  = '{1'b0, 3'b010, 32'h0000_0064, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vt[3]  = '{1'b1, 3'b010, 32'h0000_0010, 32'h80FF_7F01, 32'h0000_0000, 1'b0};
    vt[4]  = '{1'b0, 3'b000, 32'h0000_0011, 32'h0000_0000, 32'h0000_007F, 1'b0};
    vt[5]  = '{1'b0, 3'b000, 32'h0000_0013, 32'h0000_0000, 32'hFFFF_FF80, 1'b0};
    vt[6]  = '{1'b0, 3'b100, 32'h0000_0012, 32'h0000_0000, 32'h0000_00FF, 1'b0};
    vt[7]  = '{1'b0, 3'b001, 32'h0000_0012, 32'h0000_0000, 32'hFFFF_80FF, 1'b0};
    vt[8]  = '{1'b0, 3'b101, 32'h0000_0010, 32'h0000_0000, 32'h0000_7F01, 1'b0};
    vt[9]  = '{1'b1, 3'b010, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000, 1'b0};
    vt[10] = '{1'b1, 3'b000, 32'h0000_0021, 32'hFFFF_FFAA, 32'h0000_0000, 1'b0};
    vt[11] = '{1'b1, 3'b001, 32'h0000_0022, 32'h1234_BBCC, 32'h0000_0000, 1'b0};
    vt[12] = '{1'b0, 3'b010, 32'h0000_0020, 32'h0000_0000, 32'hBBCC_AA44, 1'b0};
    vt[13] = '{1'b0, 3'b010, 32'h0000_0022, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[14] = '{1'b0, 3'b001, 32'h0000_0023, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[15] = '{1'b1, 3'b010, 32'h0000_0400, 32'h5555_5555, 32'h0000_0000, 1'b1};
    vt[16] = '{1'b0, 3'b011, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[17] = '{1'b1, 3'b100, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vt[18] = '{1'b1, 3'b001, 32'h0000_0021, 32'h0000_9999, 32'h0000_0000, 1'b1};
    vt[19] = '{1'b0, 3'b010, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[20] = '{1'b0, 3'b010, 32'h0000_0020, 32'h0000_0000, 32'hBBCC_AA44, 1'b0};
    vt[21] = '{1'b0, 3'b010, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vt[22] = '{1'b0, 3'b010, 32'h0000_0064, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vt[23] = '{1'b0, 3'b101, 32'h0000_0012, 32'h0000_0000, 32'h0000_80FF, 1'b0};

    for (int d = 0; d < 4; d++) begin
      rst_n[d] = 1'b0; rv[d] = 1'b0; tb_we[d] = 1'b0; tb_f3[d] = 3'b000;
      tb_addr[d] = 32'h0; tb_wd[d] = 32'h0;
      last_acc[d] = -1; nacc[d] = 0; prev_v[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("dut%0d_rst_ready", d), 32'(rdy[d]), 32'h1);
      check($sformatf("dut%0d_rst_valid", d), 32'(vld[d]), 32'h0);
      check($sformatf("dut%0d_rst_rdata", d), rd[d], 32'h0);
      check($sformatf("dut%0d_rst_err", d), 32'(err[d]), 32'h0);
    end
    for (int d = 0; d < 4; d++) rst_n[d] = 1'b1;

    // Vector table on the LATENCY = 1 instance.
    for (int i = 0; i < 24; i++) begin
      txn(0, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, r, e, lat, nlow);
      check($sformatf("vec%0d_rdata", i), r, vt[i].rdata);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].err));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(lat_of(0)));
      check($sformatf("vec%0d_ready_low", i), 32'(nlow), 32'(lat_of(0) + 1));
    end

    // Back-to-back requests on the LATENCY = 0 and LATENCY = 7 instances.
    @(negedge clk);
    for (int k = 1; k <= 2; k++) begin
      tb_we[k] = 1'b1; tb_f3[k] = 3'b010; tb_addr[k] = 32'h0; tb_wd[k] = 32'h1234_0000;
      rv[k] = 1'b1;
    end
    for (int c = 0; c < 80; c++) begin
      for (int k = 1; k <= 2; k++) begin
        if (vld[k]) begin
          check($sformatf("dut%0d_rsp_width_c%0d", k, c), 32'(prev_v[k]), 32'h0);
          check($sformatf("dut%0d_rsp_offset_c%0d", k, c), 32'(c - last_acc[k]),
                32'(lat_of(k) + 1));
        end
        if (rdy[k]) begin
          if (last_acc[k] >= 0)
            check($sformatf("dut%0d_accept_gap_c%0d", k, c), 32'(c - last_acc[k]),
                  32'(lat_of(k) + 2));
          last_acc[k] = c;
          nacc[k]++;
        end
        prev_v[k] = vld[k];
      end
      @(negedge clk);
    end
    rv[1] = 1'b0; rv[2] = 1'b0;
    check("dut1_accept_count", 32'(nacc[1]), 32'd40);
    check("dut2_accept_count", 32'(nacc[2]), 32'd9);
    repeat (12) @(negedge clk);
    check("dut2_drained_ready", 32'(rdy[2]), 32'h1);

    // Reset during the second WAIT cycle of a store on the LATENCY = 3 instance.
    txn(3, 1'b1, 3'b010, 32'h40, 32'h0, r, e, lat, nlow);
    check("dut3_init_store_err", 32'(e), 32'h0);
    @(negedge clk);
    tb_we[3] = 1'b1; tb_f3[3] = 3'b010; tb_addr[3] = 32'h40; tb_wd[3] = 32'h1234_5678;
    rv[3] = 1'b1;
    @(posedge clk); #1;
    rv[3] = 1'b0;
    check("dut3_wait1_ready", 32'(rdy[3]), 32'h0);
    @(posedge clk); #1;
    rst_n[3] = 1'b0;
    #1;
    check("dut3_inreset_ready", 32'(rdy[3]), 32'h1);
    check("dut3_inreset_valid", 32'(vld[3]), 32'h0);
    #2;
    rst_n[3] = 1'b1;
    nrsp = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (vld[3]) nrsp++;
    end
    check("dut3_no_response", 32'(nrsp), 32'h0);
    check("dut3_ready_after_reset", 32'(rdy[3]), 32'h1);
    txn(3, 1'b0, 3'b010, 32'h40, 32'h0, r, e, lat, nlow);
    check("dut3_discarded_store", r, 32'h0);
    check("dut3_load_err", 32'(e), 32'h0);
    check("dut3_load_latency", 32'(lat), 32'(lat_of(3)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
